// File: rtl/prbs_pkg.sv
// Shared types and constants for the multi-lane PRBS transmitter.
package prbs_pkg;

  // Transmitter control states.
  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDone
  } state_e;

  // Standard PRBS polynomials: feedback = s[Len-1] ^ s[Tap-1].
  localparam int unsigned Prbs7Len  = 7;
  localparam int unsigned Prbs7Tap  = 6;
  localparam int unsigned Prbs9Len  = 9;
  localparam int unsigned Prbs9Tap  = 5;
  localparam int unsigned Prbs15Len = 15;
  localparam int unsigned Prbs15Tap = 14;
  localparam int unsigned Prbs23Len = 23;
  localparam int unsigned Prbs23Tap = 18;
  localparam int unsigned Prbs31Len = 31;
  localparam int unsigned Prbs31Tap = 28;

  // Lane k starts from all-ones XOR k, so every lane sits at a different
  // point of the same maximal-length sequence.
  function automatic logic [31:0] lane_seed(input int unsigned len, input int unsigned k);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF >> (32 - len);
    return ones ^ k;
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// One PRBS lane: Fibonacci LFSR shifting left with feedback into the LSB.
module prbs_lfsr #(
  parameter int unsigned       Length = 7,
  parameter int unsigned       Tap    = 6,
  parameter logic [Length-1:0] Seed   = '1,
  parameter bit                Invert = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic advance,
  output logic lfsr_bit
);

  logic [Length-1:0] s_q, s_d;

  // Next LFSR state: reload the seed, or shift one step on advance.
  always_comb begin
    s_d = s_q;
    if (load) begin
      s_d = Seed;
    end else if (advance) begin
      s_d = {s_q[Length-2:0], s_q[Length-1] ^ s_q[Tap-1]};
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= Seed;
    end else begin
      s_q <= s_d;
    end
  end

  assign lfsr_bit = s_q[Length-1] ^ Invert;

endmodule

// File: rtl/prbs_multi_tx.sv
// Multi-lane PRBS transmitter with programmable bit rate, framed or
// continuous operation and per-lane single-bit error injection.
module prbs_multi_tx
  import prbs_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned POLY_LENGTH = 7,
  parameter int unsigned POLY_TAP    = 6,
  parameter bit          INV_PATTERN = 1'b0,
  parameter int unsigned SPEED_W     = 4,
  parameter int unsigned FRAME_W     = 16,
  parameter bit          IDLE_LEVEL  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [SPEED_W-1:0]  speed_ctr,
  input  logic [FRAME_W-1:0]  frame_len,
  input  logic [CHANNELS-1:0] err_inject_mask,
  input  logic                err_inject,
  output logic [CHANNELS-1:0] data_out,
  output logic                bit_valid,
  output logic                busy,
  output logic                done
);

  state_e              state_q, state_d;
  logic [SPEED_W-1:0]  speed_q, speed_d;
  logic [SPEED_W-1:0]  div_q, div_d;
  logic [FRAME_W-1:0]  len_q, len_d;
  logic [FRAME_W-1:0]  cnt_q, cnt_d;
  logic [CHANNELS-1:0] inj_q, inj_d;
  logic [CHANNELS-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic [CHANNELS-1:0] lane_bit;
  logic                tick;
  logic                load;
  logic                frame_end;

  // One LFSR per lane, all advanced together on each bit tick.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    localparam logic [POLY_LENGTH-1:0] LaneSeed = POLY_LENGTH'(lane_seed(POLY_LENGTH, k));

    prbs_lfsr #(
      .Length(POLY_LENGTH),
      .Tap   (POLY_TAP),
      .Seed  (LaneSeed),
      .Invert(INV_PATTERN)
    ) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .advance (tick),
      .lfsr_bit(lane_bit[k])
    );
  end

  // Control FSM, rate divider, bit counter and output data next-state.
  always_comb begin
    state_d   = state_q;
    speed_d   = speed_q;
    len_d     = len_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    tick      = 1'b0;
    load      = 1'b0;
    frame_end = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSend;
          speed_d = speed_ctr;
          len_d   = frame_len;
          div_d   = '0;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      StSend: begin
        // The last bit has had its full period once the next tick would fall.
        frame_end = (div_q == '0) && (len_q != '0) && (cnt_q == len_q);
        if (stop || frame_end) begin
          state_d = StDone;
          data_d  = {CHANNELS{IDLE_LEVEL}};
        end else begin
          div_d = (div_q == speed_q) ? '0 : div_q + 1'b1;
          if (div_q == '0) begin
            tick    = 1'b1;
            valid_d = 1'b1;
            data_d  = lane_bit ^ inj_q;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Injection flags: a tick consumes the current flags before new ones are
  // armed, so a request coincident with a tick lands on the following bit.
  always_comb begin
    inj_d = inj_q;
    if (tick) begin
      inj_d = '0;
    end
    if (err_inject) begin
      inj_d = inj_d | err_inject_mask;
    end
    if (state_q == StDone) begin
      inj_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      speed_q <= '0;
      len_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      inj_q   <= '0;
      data_q  <= {CHANNELS{IDLE_LEVEL}};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      len_q   <= len_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      inj_q   <= inj_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign bit_valid = valid_q;
  assign busy      = (state_q == StSend);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_prbs_multi_tx.sv
// Self-checking bench for prbs_multi_tx against a PRBS7 recurrence model.
module tb_prbs_multi_tx;

  localparam int Ch = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic [3:0]    speed_ctr;
  logic [15:0]   frame_len;
  logic [Ch-1:0] err_inject_mask;
  logic          err_inject;
  logic [Ch-1:0] data_out;
  logic          bit_valid;
  logic          busy;
  logic          done;

  prbs_multi_tx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stop           (stop),
    .speed_ctr      (speed_ctr),
    .frame_len      (frame_len),
    .err_inject_mask(err_inject_mask),
    .err_inject     (err_inject),
    .data_out       (data_out),
    .bit_valid      (bit_valid),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Reference PRBS7 output per lane: o[n+7] = o[n] ^ o[n+1], first seven
  // bits are the seed read MSB first.
  bit            ref_seq [Ch][512];
  logic [Ch-1:0] cap [512];
  int            n_bits;
  int            done_edge;
  int            hold_err;
  int            valid_edges [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    assert (obs === exp)
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mism(input int lane, input int nb, input int inj_idx,
                              input logic [3:0] mask);
    int m = 0;
    for (int i = 0; i < nb; i++) begin
      bit e;
      e = ref_seq[lane][i] ^ ((i == inj_idx) && mask[lane]);
      if (cap[i][lane] !== e) m++;
    end
    return m;
  endfunction

  // Starts a frame and records every bit until done. Edge numbers count
  // clock edges after the one that samples start.
  task automatic run_frame(input int spd, input int len, input int inj_edge,
                           input logic [3:0] mask, input int stop_edge,
                           input int restart_edge, input bit stop_with_start);
    logic [Ch-1:0] last;
    n_bits    = 0;
    done_edge = -1;
    hold_err  = 0;
    valid_edges.delete();
    last      = '0;
    speed_ctr = 4'(spd);
    frame_len = 16'(len);
    start     = 1'b1;
    stop      = stop_with_start;
    @(posedge clk); #1;
    start     = 1'b0;
    stop      = 1'b0;
    // Latched values must not be disturbed by later changes.
    speed_ctr = 4'($urandom());
    frame_len = 16'($urandom());
    for (int c = 0; c < 2000; c++) begin
      err_inject      = (c + 1 == inj_edge);
      err_inject_mask = mask;
      stop            = (c + 1 == stop_edge);
      start           = (c + 1 == restart_edge);
      @(posedge clk); #1;
      if (bit_valid) begin
        if (n_bits < 512) cap[n_bits] = data_out;
        n_bits++;
        valid_edges.push_back(c + 1);
        last = data_out;
      end else if (busy && data_out !== last) begin
        hold_err++;
      end
      if (done) begin
        done_edge = c + 1;
        break;
      end
    end
    err_inject = 1'b0;
    stop       = 1'b0;
    start      = 1'b0;
  endtask

  task automatic check_end(input string tag);
    check({tag, "_idle_level"}, data_out, 4'b0000);
    check({tag, "_busy_low"}, busy, 1'b0);
    @(posedge clk); #1;
    check({tag, "_done_single"}, done, 1'b0);
  endtask

  initial begin
    logic [6:0] seed;
    int ones, eq_pairs, per_err, spd, len, ie, idx;
    logic [3:0] msk;

    for (int l = 0; l < Ch; l++) begin
      seed = 7'h7F ^ 7'(l);
      for (int t = 0; t < 7; t++) ref_seq[l][t] = seed[6-t];
      for (int n = 0; n + 7 < 512; n++) ref_seq[l][n+7] = ref_seq[l][n] ^ ref_seq[l][n+1];
    end

    rst_n = 1'b0; start = 0; stop = 0; speed_ctr = 0; frame_len = 0;
    err_inject = 0; err_inject_mask = 0;
    repeat (3) @(posedge clk); #1;
    check("rst_data", data_out, 4'b0000);
    check("rst_valid", bit_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stop in idle does nothing.
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("idle_stop_busy", busy, 1'b0);
    check("idle_stop_done", done, 1'b0);

    // Full PRBS7 frame at one bit per clock.
    run_frame(0, 127, -1, 4'b0, -1, -1, 1'b0);
    check("prbs7_bits", n_bits, 127);
    check("prbs7_first_edge", valid_edges[0], 1);
    check("prbs7_done_edge", done_edge, 128);
    ones = 0;
    for (int i = 0; i < 7; i++) ones += cap[i][0];
    check("prbs7_first7", ones, 7);
    check("prbs7_bit8", cap[7][0], 1'b0);
    ones = 0;
    for (int i = 0; i < 127; i++) ones += cap[i][0];
    check("prbs7_ones", ones, 64);
    for (int l = 0; l < Ch; l++) check($sformatf("prbs7_lane%0d", l), mism(l, 127, -1, 0), 0);
    eq_pairs = 0;
    for (int a = 0; a < Ch; a++)
      for (int b = a + 1; b < Ch; b++) begin
        int d = 0;
        for (int i = 0; i < 127; i++) if (cap[i][a] != cap[i][b]) d++;
        if (d == 0) eq_pairs++;
      end
    check("lanes_distinct", eq_pairs, 0);
    check_end("prbs7");

    // Rate divider: five cycles per bit, three bits.
    run_frame(4, 3, -1, 4'b0, -1, -1, 1'b0);
    check("rate_bits", n_bits, 3);
    if (n_bits == 3) begin
      check("rate_v0", valid_edges[0], 1);
      check("rate_v1", valid_edges[1], 6);
      check("rate_v2", valid_edges[2], 11);
    end
    check("rate_done_edge", done_edge, 16);
    check("rate_hold", hold_err, 0);
    check("rate_data", mism(0, 3, -1, 0) + mism(3, 3, -1, 0), 0);
    check_end("rate");

    // Error injection on lane 1 mid-frame (edge 40 is a tick edge, so bit 40).
    run_frame(0, 127, 40, 4'b0010, -1, -1, 1'b0);
    check("inj_done_edge", done_edge, 128);
    check("inj_lane1_diff", mism(1, 127, -1, 0), 1);
    check("inj_lane1_model", mism(1, 127, 40, 4'b0010), 0);
    check("inj_others", mism(0, 127, -1, 0) + mism(2, 127, -1, 0) + mism(3, 127, -1, 0), 0);
    check_end("inj");

    // Continuous mode, stopped after 300 bits.
    run_frame(0, 0, -1, 4'b0, 301, -1, 1'b0);
    check("cont_bits", n_bits, 300);
    check("cont_done_edge", done_edge, 301);
    per_err = 0;
    for (int i = 0; i + 127 < 300; i++) if (cap[i] !== cap[i+127]) per_err++;
    check("cont_period", per_err, 0);
    check("cont_model", mism(0, 300, -1, 0) + mism(2, 300, -1, 0), 0);
    check_end("cont");

    // Randomised frames: start with stop held, random rate, length and injection.
    for (int r = 0; r < 3; r++) begin
      spd = $urandom_range(1, 3);
      len = $urandom_range(8, 30);
      ie  = $urandom_range(2, (len - 3) * (spd + 1));
      msk = 4'($urandom_range(1, 15));
      idx = (ie - 1) / (spd + 1) + 1;
      run_frame(spd, len, ie, msk, -1, -1, 1'b1);
      check($sformatf("rnd%0d_bits", r), n_bits, len);
      check($sformatf("rnd%0d_done_edge", r), done_edge, 1 + len * (spd + 1));
      check($sformatf("rnd%0d_hold", r), hold_err, 0);
      check($sformatf("rnd%0d_model", r),
            mism(0, len, idx, msk) + mism(1, len, idx, msk) +
            mism(2, len, idx, msk) + mism(3, len, idx, msk), 0);
      check_end($sformatf("rnd%0d", r));
    end

    // Asynchronous reset in the middle of a frame.
    speed_ctr = 0; frame_len = 127; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (i >= 10 && data_out != 4'b0000) break;
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data", data_out, 4'b0000);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_valid", bit_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // New frame restarts from the seed; a start while busy is ignored.
    run_frame(0, 127, -1, 4'b0, -1, 10, 1'b0);
    check("restart_bits", n_bits, 127);
    check("restart_done_edge", done_edge, 128);
    check("restart_model", mism(0, 127, -1, 0) + mism(3, 127, -1, 0), 0);
    check_end("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
